// File: rtl/fetch_stage.sv
// Fetch stage: latches the next-PC group, pairs it with the I-cache line, applies
// held/live branch predictions, truncates after the first taken slot and feeds decode.
module fetch_stage #(
    parameter int FETCH_WIDTH = 2,
    parameter int PC_WIDTH    = 32,
    parameter int INSN_WIDTH  = 32,
    parameter int LINE_BYTES  = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [FETCH_WIDTH-1:0]          npValid,
    input  logic [PC_WIDTH-1:0]             npPC,
    input  logic                            stall,
    input  logic                            clear,
    input  logic                            icHit,
    input  logic [LINE_BYTES*8-1:0]         icLine,
    input  logic [FETCH_WIDTH-1:0]          btbHit,
    input  logic [FETCH_WIDTH*PC_WIDTH-1:0] btbOut,
    input  logic [FETCH_WIDTH-1:0]          brPredTaken,
    output logic [FETCH_WIDTH-1:0]          fetchStageIsValid,
    output logic [FETCH_WIDTH*PC_WIDTH-1:0] fetchStagePC,
    output logic [FETCH_WIDTH-1:0]          btbHitOut,
    output logic [FETCH_WIDTH*PC_WIDTH-1:0] btbTargetOut,
    output logic [FETCH_WIDTH-1:0]          predTakenOut,
    output logic                            icMissStallReq,
    output logic [FETCH_WIDTH-1:0]          decValid,
    output logic [FETCH_WIDTH*PC_WIDTH-1:0] decPC,
    output logic [FETCH_WIDTH*INSN_WIDTH-1:0] decInsn,
    output logic [FETCH_WIDTH-1:0]          decPredTaken,
    output logic                            dbg_state
);
    localparam int OFF_W = $clog2(LINE_BYTES);
    localparam int IDX_W = OFF_W - 2;

    typedef enum logic {ST_RUN = 1'b0, ST_MISS = 1'b1} state_e;

    state_e                          state_q, state_d;
    logic [FETCH_WIDTH-1:0]          reg_valid_q, reg_valid_d;
    logic [PC_WIDTH-1:0]             reg_pc_q, reg_pc_d;
    logic                            reg_stall_q, reg_stall_d;
    logic [FETCH_WIDTH-1:0]          held_hit_q, held_hit_d;
    logic [FETCH_WIDTH-1:0]          held_taken_q, held_taken_d;
    logic [FETCH_WIDTH*PC_WIDTH-1:0] held_tgt_q, held_tgt_d;

    logic [FETCH_WIDTH-1:0]          eff_hit, eff_taken;
    logic [FETCH_WIDTH*PC_WIDTH-1:0] eff_tgt;
    logic [IDX_W:0]                  word_idx [FETCH_WIDTH];
    logic [FETCH_WIDTH-1:0]          line_ok, trunc_ok;
    logic                            taken_seen;
    logic [PC_WIDTH-1:0]             slot_pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_RUN;
            reg_valid_q  <= '0;
            reg_pc_q     <= '0;
            reg_stall_q  <= 1'b0;
            held_hit_q   <= '0;
            held_taken_q <= '0;
            held_tgt_q   <= '0;
        end else begin
            state_q      <= state_d;
            reg_valid_q  <= reg_valid_d;
            reg_pc_q     <= reg_pc_d;
            reg_stall_q  <= reg_stall_d;
            held_hit_q   <= held_hit_d;
            held_taken_q <= held_taken_d;
            held_tgt_q   <= held_tgt_d;
        end
    end

    // Pipeline register and prediction capture; clear beats stall.
    always_comb begin
        reg_valid_d  = reg_valid_q;
        reg_pc_d     = reg_pc_q;
        reg_stall_d  = stall;
        held_hit_d   = held_hit_q;
        held_taken_d = held_taken_q;
        held_tgt_d   = held_tgt_q;
        if (clear) begin
            reg_valid_d  = '0;
            held_hit_d   = '0;
            held_taken_d = '0;
            held_tgt_d   = '0;
        end else begin
            if (!stall) begin
                reg_valid_d = npValid;
                reg_pc_d    = npPC;
            end
            if (stall && !reg_stall_q) begin
                held_hit_d   = btbHit;
                held_taken_d = brPredTaken;
                held_tgt_d   = btbOut;
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        icMissStallReq = 1'b0;
        case (state_q)
            ST_RUN: begin
                if ((|reg_valid_q) && !icHit && !clear) begin
                    state_d        = ST_MISS;
                    icMissStallReq = 1'b1;
                end
            end
            ST_MISS: begin
                if (clear || icHit) state_d = ST_RUN;
                else                icMissStallReq = 1'b1;
            end
            default: state_d = ST_RUN;
        endcase
    end

    assign dbg_state = state_q;

    // Slot outputs are zeroed for invalid register slots so reset shows all-zero outputs.
    always_comb begin
        eff_hit           = reg_stall_q ? held_hit_q   : btbHit;
        eff_taken         = reg_stall_q ? held_taken_q : brPredTaken;
        eff_tgt           = reg_stall_q ? held_tgt_q   : btbOut;
        taken_seen        = 1'b0;
        slot_pc           = '0;
        line_ok           = '0;
        trunc_ok          = '0;
        fetchStageIsValid = reg_valid_q;
        fetchStagePC      = '0;
        btbHitOut         = '0;
        btbTargetOut      = '0;
        predTakenOut      = '0;
        decValid          = '0;
        decPC             = '0;
        decInsn           = '0;
        decPredTaken      = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            word_idx[i] = {1'b0, reg_pc_q[OFF_W-1:2]} + (IDX_W+1)'(i);
            slot_pc     = reg_pc_q + PC_WIDTH'(4 * i);
            // A slot whose word index wraps past the line end is never decoded.
            line_ok[i]  = reg_valid_q[i] && !word_idx[i][IDX_W];
            trunc_ok[i] = line_ok[i] && !taken_seen;
            if (line_ok[i] && eff_hit[i] && eff_taken[i]) taken_seen = 1'b1;
            if (reg_valid_q[i]) begin
                fetchStagePC[i*PC_WIDTH +: PC_WIDTH] = slot_pc;
                decPC[i*PC_WIDTH +: PC_WIDTH]        = slot_pc;
                btbHitOut[i]                         = eff_hit[i];
                predTakenOut[i]                      = eff_taken[i];
                btbTargetOut[i*PC_WIDTH +: PC_WIDTH] = eff_tgt[i*PC_WIDTH +: PC_WIDTH];
                decInsn[i*INSN_WIDTH +: INSN_WIDTH]  =
                    icLine[INSN_WIDTH*int'(word_idx[i][IDX_W-1:0]) +: INSN_WIDTH];
            end
            decValid[i]     = trunc_ok[i] && icHit && !stall && !clear;
            decPredTaken[i] = decValid[i] && eff_hit[i] && eff_taken[i];
        end
    end
endmodule
